// File: rtl/simd_mac_pkg.sv
// Shared mode encodings and width helpers for the SIMD multiply-accumulate slice.
package simd_mac_pkg;

  localparam logic [1:0] MODE_FULL = 2'b00;
  localparam logic [1:0] MODE_SUM2 = 2'b01;

  // Half of a bus: FULL operand width, or one SUM2 lane of the operand bus.
  function automatic int half_w(input int w);
    return w / 2;
  endfunction

  // Width of one sub-operand inside a SUM2 lane.
  function automatic int quarter_w(input int in_w);
    return in_w / 4;
  endfunction

  // Width of one accumulator lane in SUM2 mode.
  function automatic int lane_w(input int acc_w);
    return acc_w / 2;
  endfunction

  // Lowest operand bit covered by SUM2 lane k.
  function automatic int lane_lsb(input int in_w, input int k);
    return k * (in_w / 2);
  endfunction

  // Reserved encodings behave as FULL.
  function automatic logic [1:0] norm_mode(input logic [1:0] m);
    return (m == MODE_SUM2) ? MODE_SUM2 : MODE_FULL;
  endfunction

endpackage

// File: rtl/simd_mult_core.sv
// Combinational product generator: one IN_W/2 x IN_W/2 product (FULL) or two
// lanes each holding lo*lo + hi*hi of IN_W/4-bit halves (SUM2). Each operand is
// widened by one bit according to its sign flag before multiplying.
module simd_mult_core
  import simd_mac_pkg::*;
#(
  parameter int IN_W  = 32,
  parameter int ACC_W = 48
) (
  input  logic [IN_W-1:0]         a,
  input  logic [IN_W-1:0]         b,
  input  logic                    a_sign,
  input  logic                    b_sign,
  input  logic [1:0]              mode,
  output logic signed [ACC_W-1:0] prod
);

  localparam int H  = half_w(IN_W);
  localparam int Q  = quarter_w(IN_W);
  localparam int LW = lane_w(ACC_W);
  localparam int FW = IN_W + 2;
  localparam int SW = 2 * Q + 3;

  logic signed [FW-1:0] a_full;
  logic signed [FW-1:0] b_full;
  logic signed [FW-1:0] p_full;
  logic [ACC_W-1:0]     full_ext;
  logic [ACC_W-1:0]     sum2_ext;

  // Operands are extended all the way to the product width so the multiply
  // is evaluated at full precision without relying on context widening.
  assign a_full   = {{(FW-H){a_sign & a[H-1]}}, a[H-1:0]};
  assign b_full   = {{(FW-H){b_sign & b[H-1]}}, b[H-1:0]};
  assign p_full   = a_full * b_full;
  assign full_ext = {{(ACC_W-FW){p_full[FW-1]}}, p_full};

  for (genvar k = 0; k < 2; k++) begin : g_lane
    localparam int L = lane_lsb(IN_W, k);
    logic signed [SW-1:0] a_lo;
    logic signed [SW-1:0] a_hi;
    logic signed [SW-1:0] b_lo;
    logic signed [SW-1:0] b_hi;
    logic signed [SW-1:0] lane_sum;
    assign a_lo     = {{(SW-Q){a_sign & a[L+Q-1]}},   a[L +: Q]};
    assign a_hi     = {{(SW-Q){a_sign & a[L+2*Q-1]}}, a[L+Q +: Q]};
    assign b_lo     = {{(SW-Q){b_sign & b[L+Q-1]}},   b[L +: Q]};
    assign b_hi     = {{(SW-Q){b_sign & b[L+2*Q-1]}}, b[L+Q +: Q]};
    assign lane_sum = a_lo * b_lo + a_hi * b_hi;
    assign sum2_ext[k*LW +: LW] = {{(LW-SW){lane_sum[SW-1]}}, lane_sum};
  end

  assign prod = (mode == MODE_SUM2) ? sum2_ext : full_ext;

endmodule

// File: rtl/simd_mac_pipelined.sv
// Three-stage SIMD multiply-accumulate with first/last framing, sticky per-lane
// signed overflow and valid/ready handshakes. A single stall (output held and
// not accepted) freezes every stage.
module simd_mac_pipelined
  import simd_mac_pkg::*;
#(
  parameter int IN_W  = 32,
  parameter int ACC_W = 48
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_first,
  input  logic              in_last,
  input  logic [1:0]        mode,
  input  logic              a_sign,
  input  logic              b_sign,
  input  logic [IN_W-1:0]   a,
  input  logic [IN_W-1:0]   b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_result,
  output logic [1:0]        out_overflow,
  output logic [1:0]        out_mode
);

  localparam int LW = lane_w(ACC_W);

  // Two's-complement overflow: addends agree in sign, sum does not.
  function automatic logic signed_ovf(input logic x_msb, input logic y_msb,
                                      input logic s_msb);
    return (x_msb == y_msb) && (s_msb != x_msb);
  endfunction

  logic stall;
  logic accept;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;
  assign accept   = in_valid & in_ready;

  // ---- stage 1: operand capture ----
  logic             vld_p0;
  logic             first_p0;
  logic             last_p0;
  logic [1:0]       mode_p0;
  logic [1:0]       mode_lat;
  logic [IN_W-1:0]  a_p0;
  logic [IN_W-1:0]  b_p0;
  logic             a_sign_p0;
  logic             b_sign_p0;

  // Stage-1 control; the frame mode is latched only on an accepted first beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p0   <= 1'b0;
      first_p0 <= 1'b0;
      last_p0  <= 1'b0;
      mode_p0  <= MODE_FULL;
      mode_lat <= MODE_FULL;
    end else if (!stall) begin
      vld_p0   <= accept;
      first_p0 <= in_first;
      last_p0  <= in_last;
      mode_p0  <= in_first ? norm_mode(mode) : mode_lat;
      if (accept && in_first) mode_lat <= norm_mode(mode);
    end
  end

  // Stage-1 operand registers; loaded only when a beat transfers.
  always_ff @(posedge clk) begin
    if (!stall && accept) begin
      a_p0      <= a;
      b_p0      <= b;
      a_sign_p0 <= a_sign;
      b_sign_p0 <= b_sign;
    end
  end

  // ---- stage 2: products ----
  logic signed [ACC_W-1:0] prod_c;
  logic signed [ACC_W-1:0] prod_p1;
  logic                    vld_p1;
  logic                    first_p1;
  logic                    last_p1;
  logic [1:0]              mode_p1;

  simd_mult_core #(
    .IN_W  (IN_W),
    .ACC_W (ACC_W)
  ) u_core (
    .a      (a_p0),
    .b      (b_p0),
    .a_sign (a_sign_p0),
    .b_sign (b_sign_p0),
    .mode   (mode_p0),
    .prod   (prod_c)
  );

  // Stage-2 control follows stage 1 whenever the pipe advances.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1   <= 1'b0;
      first_p1 <= 1'b0;
      last_p1  <= 1'b0;
      mode_p1  <= MODE_FULL;
    end else if (!stall) begin
      vld_p1   <= vld_p0;
      first_p1 <= first_p0;
      last_p1  <= last_p0;
      mode_p1  <= mode_p0;
    end
  end

  // Stage-2 product register.
  always_ff @(posedge clk) begin
    if (!stall && vld_p0) prod_p1 <= prod_c;
  end

  // ---- stage 3: accumulate ----
  logic signed [ACC_W-1:0] acc_p2;
  logic [1:0]              ovf_p2;
  logic                    vld_p2;
  logic                    last_p2;
  logic [1:0]              mode_p2;

  logic signed [ACC_W-1:0] base;
  logic [1:0]              base_ovf;
  logic signed [ACC_W-1:0] full_sum;
  logic [LW-1:0]           lane0_sum;
  logic [LW-1:0]           lane1_sum;
  logic signed [ACC_W-1:0] acc_nxt;
  logic [1:0]              ovf_nxt;

  // A first beat starts from zero with cleared flags; lanes add independently.
  always_comb begin
    base      = first_p1 ? '0 : acc_p2;
    base_ovf  = first_p1 ? 2'b00 : ovf_p2;
    full_sum  = base + prod_p1;
    lane0_sum = base[LW-1:0] + prod_p1[LW-1:0];
    lane1_sum = base[ACC_W-1:LW] + prod_p1[ACC_W-1:LW];
    acc_nxt   = full_sum;
    ovf_nxt   = {1'b0, base_ovf[0] |
                 signed_ovf(base[ACC_W-1], prod_p1[ACC_W-1], full_sum[ACC_W-1])};
    if (mode_p1 == MODE_SUM2) begin
      acc_nxt = {lane1_sum, lane0_sum};
      ovf_nxt = base_ovf |
                {signed_ovf(base[ACC_W-1], prod_p1[ACC_W-1], lane1_sum[LW-1]),
                 signed_ovf(base[LW-1],    prod_p1[LW-1],    lane0_sum[LW-1])};
    end
  end

  // Accumulator and sticky flags change only on valid beats.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p2  <= 1'b0;
      last_p2 <= 1'b0;
      mode_p2 <= MODE_FULL;
      acc_p2  <= '0;
      ovf_p2  <= 2'b00;
    end else if (!stall) begin
      vld_p2  <= vld_p1;
      last_p2 <= last_p1;
      if (vld_p1) begin
        acc_p2  <= acc_nxt;
        ovf_p2  <= ovf_nxt;
        mode_p2 <= mode_p1;
      end
    end
  end

  // ---- output register ----
  // A completed frame loads the result; otherwise an accepted result retires.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid    <= 1'b0;
      out_result   <= '0;
      out_overflow <= 2'b00;
      out_mode     <= MODE_FULL;
    end else if (!stall) begin
      out_valid <= vld_p2 & last_p2;
      if (vld_p2 && last_p2) begin
        out_result   <= acc_p2;
        out_overflow <= ovf_p2;
        out_mode     <= mode_p2;
      end
    end
  end

endmodule

// File: tb/tb_simd_mac_pipelined.sv
// Self-checking bench for simd_mac_pipelined (IN_W=32, ACC_W=48).
module tb_simd_mac_pipelined;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        in_first;
  logic        in_last;
  logic [1:0]  mode;
  logic        a_sign;
  logic        b_sign;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [47:0] out_result;
  logic [1:0]  out_overflow;
  logic [1:0]  out_mode;

  int total = 0;
  int bad   = 0;
  bit abort_run = 0;

  simd_mac_pipelined #(.IN_W(32), .ACC_W(48)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_first     (in_first),
    .in_last      (in_last),
    .mode         (mode),
    .a_sign       (a_sign),
    .b_sign       (b_sign),
    .a            (a),
    .b            (b),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_overflow (out_overflow),
    .out_mode     (out_mode)
  );

  always #5 clk = ~clk;

  // Reference model: exact integer arithmetic, range-checked for overflow.
  typedef struct {
    logic [47:0] res;
    logic [1:0]  ovf;
    logic [1:0]  md;
  } exp_t;

  exp_t       exp_q[$];
  longint     m_full = 0;
  longint     m_lane0 = 0;
  longint     m_lane1 = 0;
  logic [1:0] m_ovf = 2'b00;
  logic [1:0] m_mode = 2'b00;

  function automatic longint fld(logic [31:0] x, int lsb, int w, bit sgn);
    longint v = 0;
    for (int i = 0; i < w; i++) if (x[lsb+i]) v += (longint'(1) << i);
    if (sgn && x[lsb+w-1]) v -= (longint'(1) << w);
    return v;
  endfunction

  function automatic longint wrap_add(longint acc, longint p, int w, output bit ov);
    longint s   = acc + p;
    longint lim = longint'(1) << (w - 1);
    ov = 0;
    if (s >= lim) begin s -= (lim << 1); ov = 1; end
    else if (s < -lim) begin s += (lim << 1); ov = 1; end
    return s;
  endfunction

  function void model_reset();
    m_full = 0; m_lane0 = 0; m_lane1 = 0; m_ovf = 2'b00; m_mode = 2'b00;
    exp_q.delete();
  endfunction

  function void model_beat(logic [31:0] xa, logic [31:0] xb, bit sa, bit sb,
                           bit f, bit l, logic [1:0] md);
    bit ov;
    longint p;
    logic [63:0] t0;
    logic [63:0] t1;
    exp_t e;
    if (f) begin
      m_mode = (md == 2'b01) ? 2'b01 : 2'b00;
      m_full = 0; m_lane0 = 0; m_lane1 = 0; m_ovf = 2'b00;
    end
    if (m_mode == 2'b01) begin
      p = fld(xa, 0, 8, sa) * fld(xb, 0, 8, sb) + fld(xa, 8, 8, sa) * fld(xb, 8, 8, sb);
      m_lane0 = wrap_add(m_lane0, p, 24, ov);
      if (ov) m_ovf[0] = 1'b1;
      p = fld(xa, 16, 8, sa) * fld(xb, 16, 8, sb) + fld(xa, 24, 8, sa) * fld(xb, 24, 8, sb);
      m_lane1 = wrap_add(m_lane1, p, 24, ov);
      if (ov) m_ovf[1] = 1'b1;
    end else begin
      p = fld(xa, 0, 16, sa) * fld(xb, 0, 16, sb);
      m_full = wrap_add(m_full, p, 48, ov);
      if (ov) m_ovf[0] = 1'b1;
    end
    if (l) begin
      if (m_mode == 2'b01) begin
        t0 = m_lane0; t1 = m_lane1;
        e.res = {t1[23:0], t0[23:0]};
      end else begin
        t0 = m_full;
        e.res = t0[47:0];
      end
      e.ovf = m_ovf;
      e.md  = m_mode;
      exp_q.push_back(e);
    end
  endfunction

  // Drive one beat from a falling edge and hold it until it transfers.
  task automatic send_beat(input logic [31:0] xa, input logic [31:0] xb, input bit sa,
                           input bit sb, input bit f, input bit l, input logic [1:0] md);
    int n = 0;
    bit done = 0;
    if (abort_run) return;
    @(negedge clk);
    in_valid = 1'b1; a = xa; b = xb; a_sign = sa; b_sign = sb;
    in_first = f; in_last = l; mode = md;
    while (!done) begin
      #1;
      if (in_ready) begin
        @(posedge clk);
        model_beat(xa, xb, sa, sb, f, l, md);
        done = 1;
      end else begin
        @(negedge clk);
        n++;
        if (n > 2000) begin
          total++; bad++; abort_run = 1;
          $display("FAIL send_beat_timeout in_ready=%b required=1", in_ready);
          done = 1;
        end
      end
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Drop in_valid and count falling edges until out_valid is seen.
  task automatic wait_out(output int n);
    n = 0;
    do begin
      @(negedge clk);
      in_valid = 1'b0;
      #2;
      n++;
    end while (!out_valid && n < 50);
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_first = 0; in_last = 0; mode = 2'b00;
    a_sign = 0; b_sign = 0; a = '0; b = '0; out_ready = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #2;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    total++; if (out_result !== 48'h0) begin bad++; $display("FAIL reset_out_result got=%h want=0", out_result); end
    total++; if (out_overflow !== 2'b00) begin bad++; $display("FAIL reset_out_overflow got=%b want=00", out_overflow); end
    total++; if (out_mode !== 2'b00) begin bad++; $display("FAIL reset_out_mode got=%b want=00", out_mode); end
  endtask

  task automatic test_full_unsigned();
    int n;
    send_beat(32'h0000_FFFF, 32'h0000_FFFF, 0, 0, 1, 1, 2'b00);
    wait_out(n);
    total++; if (n !== 4) begin bad++; $display("FAIL full_u_latency got=%0d want=4", n); end
    total++; if (out_result !== 48'h0000_FFFE_0001) begin bad++; $display("FAIL full_u_result got=%h want=0000fffe0001", out_result); end
    total++; if (out_overflow !== 2'b00) begin bad++; $display("FAIL full_u_ovf got=%b want=00", out_overflow); end
  endtask

  task automatic test_full_signed();
    int n;
    send_beat(32'h1234_FFFF, 32'hABCD_0003, 1, 1, 1, 1, 2'b00);
    wait_out(n);
    total++; if (out_result !== 48'hFFFF_FFFF_FFFD) begin bad++; $display("FAIL full_s_result got=%h want=fffffffffffd", out_result); end
    total++; if (out_mode !== 2'b00) begin bad++; $display("FAIL full_s_mode got=%b want=00", out_mode); end
  endtask

  task automatic test_sum2_unsigned();
    int n;
    send_beat(32'h0102_0304, 32'h0506_0708, 0, 0, 1, 1, 2'b01);
    wait_out(n);
    total++; if (out_result !== {24'h000011, 24'h000035}) begin bad++; $display("FAIL sum2_u_result got=%h want=000011000035", out_result); end
    total++; if (out_mode !== 2'b01) begin bad++; $display("FAIL sum2_u_mode got=%b want=01", out_mode); end
  endtask

  task automatic test_reserved_mode();
    int n;
    send_beat(32'h0103_0003, 32'h0104_0004, 0, 0, 1, 1, 2'b10);
    wait_out(n);
    total++; if (out_result !== 48'd12) begin bad++; $display("FAIL reserved_result got=%h want=00000000000c", out_result); end
    total++; if (out_mode !== 2'b00) begin bad++; $display("FAIL reserved_mode got=%b want=00", out_mode); end
  endtask

  task automatic test_sum2_wrap();
    int n;
    for (int i = 0; i < 256; i++)
      send_beat(32'h8080_8080, 32'h8080_8080, 1, 1, i == 0, i == 255,
                (i == 0) ? 2'b01 : 2'b00);
    wait_out(n);
    total++; if (out_result !== {24'h800000, 24'h800000}) begin bad++; $display("FAIL wrap_result got=%h want=800000800000", out_result); end
    total++; if (out_overflow !== 2'b11) begin bad++; $display("FAIL wrap_ovf got=%b want=11", out_overflow); end
    total++; if (out_mode !== 2'b01) begin bad++; $display("FAIL wrap_mode got=%b want=01", out_mode); end
    send_beat(32'h8080_8080, 32'h8080_8080, 1, 1, 1, 1, 2'b01);
    wait_out(n);
    total++; if (out_result !== {24'h008000, 24'h008000}) begin bad++; $display("FAIL wrap_single_result got=%h want=008000008000", out_result); end
    total++; if (out_overflow !== 2'b00) begin bad++; $display("FAIL wrap_single_ovf got=%b want=00", out_overflow); end
  endtask

  task automatic test_backpressure();
    int n;
    @(negedge clk);
    out_ready = 1'b0;
    send_beat(32'h0000_0005, 32'h0000_0007, 0, 0, 1, 1, 2'b00);
    send_beat(32'h0000_0202, 32'h0000_0303, 0, 0, 1, 1, 2'b01);
    send_beat(32'h0000_FFFE, 32'h0000_0003, 1, 1, 1, 1, 2'b00);
    wait_out(n);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #2;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready got=%b want=0", in_ready); end
      total++; if ({out_valid, out_result} !== {1'b1, 48'd35}) begin bad++; $display("FAIL bp_hold got=%b/%h want=1/%h", out_valid, out_result, 48'd35); end
    end
    out_ready = 1'b1;
    @(negedge clk); #2;
    total++; if ({out_valid, out_mode, out_result} !== {1'b1, 2'b01, 48'h00000000000C}) begin bad++; $display("FAIL bp_second got=%b/%b/%h want=1/01/00000000000c", out_valid, out_mode, out_result); end
    @(negedge clk); #2;
    total++; if ({out_valid, out_result} !== {1'b1, 48'hFFFF_FFFF_FFFA}) begin bad++; $display("FAIL bp_third got=%b/%h want=1/fffffffffffa", out_valid, out_result); end
    @(negedge clk); #2;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_drain got=%b want=0", out_valid); end
  endtask

  task automatic test_reset_mid();
    int n;
    int seen = 0;
    send_beat(32'h0000_0007, 32'h0000_0009, 0, 0, 1, 0, 2'b01);
    send_beat(32'h0000_0007, 32'h0000_0009, 0, 0, 0, 0, 2'b01);
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #2;
      if (out_valid) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL reset_mid_no_output got=%0d want=0", seen); end
    send_beat(32'h0000_0003, 32'h0000_0004, 0, 0, 0, 1, 2'b01);
    wait_out(n);
    total++; if (n !== 4) begin bad++; $display("FAIL reset_mid_latency got=%0d want=4", n); end
    total++; if (out_result !== 48'd12) begin bad++; $display("FAIL reset_mid_result got=%h want=00000000000c", out_result); end
    total++; if (out_mode !== 2'b00) begin bad++; $display("FAIL reset_mid_mode got=%b want=00", out_mode); end
  endtask

  task automatic test_back_to_back();
    localparam int NFRAMES = 1000;
    @(negedge clk);
    exp_q.delete();
    fork
      begin
        for (int f = 0; f < NFRAMES; f++) begin
          int nb = $urandom_range(1, 4);
          logic [1:0] fm = 2'($urandom_range(0, 3));
          for (int j = 0; j < nb; j++) begin
            if ($urandom_range(0, 3) == 0) idle();
            send_beat($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      j == 0, j == nb - 1, (j == 0) ? fm : 2'($urandom_range(0, 3)));
          end
        end
        idle();
      end
      begin
        int got = 0;
        int cyc = 0;
        exp_t e;
        while (got < NFRAMES && cyc < 40000) begin
          @(negedge clk);
          out_ready = ($urandom_range(0, 3) != 0);
          #2;
          cyc++;
          if (out_valid && out_ready) begin
            got++;
            total++;
            if (exp_q.size() == 0) begin
              bad++;
              $display("FAIL rand_unexpected got=%h want=nothing", out_result);
            end else begin
              e = exp_q.pop_front();
              if ({out_result, out_overflow, out_mode} !== {e.res, e.ovf, e.md}) begin
                bad++;
                $display("FAIL rand_result#%0d got=%h/%b/%b want=%h/%b/%b", got,
                         out_result, out_overflow, out_mode, e.res, e.ovf, e.md);
              end
            end
          end
        end
        total++;
        if (got !== NFRAMES) begin
          bad++;
          $display("FAIL rand_count got=%0d want=%0d", got, NFRAMES);
        end
      end
    join
    out_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_full_unsigned();
    test_full_signed();
    test_sum2_unsigned();
    test_reserved_mode();
    test_sum2_wrap();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/simd_mac_pipelined.md
Name: simd_mac_pipelined

Overview:
- Pipelined, parametrised successor to the combinational two-mode multiplier: one full-width (IN_W/2 × IN_W/2) product, or two SIMD lanes, each the sum of two (IN_W/4 × IN_W/4) products.
- Adds a 3-stage pipeline, a multi-beat accumulator framed by first/last flags, sticky per-lane overflow, and valid/ready handshakes on input and output.
- Sits between operand staging and the PIRDSP result/cascade path.

Parameters:
- IN_W, 32, operand bus width; must be a multiple of 4 and ≥8.
- ACC_W, 48, accumulator/result width; must be even; each lane in SUM2 mode is ACC_W/2 bits.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input can be accepted; a beat transfers when in_valid & in_ready.
- in_first  in  1  beat starts a new accumulation; latches mode and clears accumulators/overflow.
- in_last  in  1  beat ends the accumulation and produces an output.
- mode  in  2  00 FULL, 01 SUM2, 1x reserved (treated as FULL); sampled only on first beats.
- a_sign  in  1  a is signed (per beat).
- b_sign  in  1  b is signed (per beat).
- a  in  IN_W  operand A.
- b  in  IN_W  operand B.
- out_valid  out  1  result valid; held until out_ready.
- out_ready  in  1  downstream accepts result.
- out_result  out  ACC_W  FULL: signed accumulator. SUM2: {lane1, lane0}, each ACC_W/2 signed.
- out_overflow  out  2  sticky signed-overflow flags. FULL uses bit0 and bit1=0; SUM2 uses one bit per lane.
- out_mode  out  2  mode of the emitted result.

Behaviour:
- Reset (synchronous, active-high):
  - All pipeline valids, accumulators and overflow flags go to 0.
  - Latched mode goes to FULL.
  - out_valid=0, out_result=0, out_overflow=0, out_mode=00.
  - Reset mid-accumulation discards the partial result; no output is produced.
- Stall:
  - stall = out_valid & ~out_ready; in_ready = ~stall (combinational).
  - While stalled, every stage holds and out_* are stable.
- Stage 1: register a, b, signs, first, last and valid. If first=1, mode is captured here.
- Stage 2 (products; sign-extend each operand by one bit per its sign flag):
  - FULL: P = a[IN_W/2-1:0] × b[IN_W/2-1:0], (IN_W+2)-bit signed, sign-extended to ACC_W.
  - SUM2 lane k (k=0,1), with Q = IN_W/4: lane k covers bits [k·IN_W/2 +: IN_W/2], split into two Q-bit halves. Lane sum = lo·lo + hi·hi, (2Q+3)-bit signed, sign-extended to ACC_W/2.
- Stage 3 (accumulate):
  - first beat: acc = P, overflow cleared.
  - otherwise: acc = acc + P, with wrap-around (two's complement).
  - Overflow flag (per lane in SUM2) ORs in signed overflow: operand signs equal and sum sign differs.
  - Lanes never carry into each other.
- Output: a last beat reaching stage 3 loads out_result/out_overflow/out_mode and sets out_valid on the next edge.
  - Latency: last beat accepted at edge t gives out_valid=1 after edge t+3 (no stall).
  - out_valid clears on out_valid & out_ready unless a new last beat completes in that same cycle. That case gives back-to-back outputs: out_valid stays 1 with new data.
- Framing edge cases:
  - first & last on the same beat: single-beat result.
  - Beats before any first after reset accumulate onto zero in FULL mode.
  - A mode change without first is ignored.
  - A first while a previous accumulation is open (no last yet) discards the old partial.
- Non-valid cycles do not modify the accumulator.

Decomposition:
- Package simd_mac_pkg holds:
  - MODE_FULL=2'b00, MODE_SUM2=2'b01.
  - Helper functions for lane slicing and width derivation (Q, lane width).
- Sub-module simd_mult_core: combinational signed/unsigned FULL/SUM2 product generator, IN_W-parametrised. Instantiated in stage 2.

Test Plan:
- FULL, a_sign=b_sign=0, a=0xFFFF, b=0xFFFF, first=last=1 → out_result=48'h0000_FFFE_0001 exactly 3 cycles after acceptance; overflow=00.
- FULL signed, a=0xFFFF (−1), b=0x0003, single beat → out_result=48'hFFFF_FFFF_FFFD.
- SUM2 unsigned, a=0x0102_0304, b=0x0506_0708, single beat → out_result={24'h000011, 24'h000035}, out_mode=01.
- SUM2 signed, every byte 0x80 in a and b, 256 beats (first on beat 1, last on beat 256) → each lane=24'h800000 (wrapped), out_overflow=2'b11. Then a single first/last beat yields overflow=00.
- Backpressure: hold out_ready=0 for 5 cycles while out_valid=1 → in_ready=0, out_* stable. Release → next queued results emerge in order, none lost or duplicated (scoreboard against 1000 random framed transactions, all sign/mode mixes).
- Assert reset for one cycle between beats 2 and 3 of a 4-beat frame → no output. A subsequent single-beat FULL 3×4 → out_result=12.
